// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback (commit) stage.
// Holds the memop encodings, the FSM state type and the default datapath width.
package wb_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        MEMOP_NONE  = 2'b00,
        MEMOP_LOAD  = 2'b01,
        MEMOP_STORE = 2'b10
    } memop_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MEM    = 2'b01,
        COMMIT = 2'b10
    } wb_state_e;

endpackage

// File: rtl/mem_req_timer.sv
// Counts cycles spent waiting for a memory acknowledge and flags expiry.
// Used by writeback_unit only when MEM_TIMEOUT_EN is defined.
module mem_req_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // Restarts from zero every time the stage leaves MEM, saturates at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (!run) begin
            count <= 8'd0;
        end else if (count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign expired = run && (count == LIMIT);

endmodule

// File: rtl/writeback_unit.sv
// Commit stage behind the ALU: optional load/store over req/ack, then register or PC write.
// Define MEM_TIMEOUT_EN to bound the ack wait with mem_req_timer and a sticky O_err.
module writeback_unit
   import wb_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int REG_SEL_W = 3,
   parameter int TIMEOUT   = 255
) (
   input  logic                 I_clk,
   input  logic                 I_rst_n,
   input  logic                 I_en,
   input  logic [DATA_W-1:0]    I_aluresult,
   input  logic                 I_shldBranch,
   input  logic [DATA_W-1:0]    I_storedata,
   input  logic [1:0]           I_memop,
   input  logic                 I_regwe,
   input  logic [REG_SEL_W-1:0] I_rD_sel,
   output logic                 O_mem_req,
   output logic                 O_mem_we,
   output logic [DATA_W-1:0]    O_mem_addr,
   output logic [DATA_W-1:0]    O_mem_wdata,
   input  logic                 I_mem_ack,
   input  logic [DATA_W-1:0]    I_mem_rdata,
   output logic                 O_reg_we,
   output logic [REG_SEL_W-1:0] O_reg_sel,
   output logic [DATA_W-1:0]    O_reg_data,
   output logic                 O_pc_load,
   output logic [DATA_W-1:0]    O_pc_target,
   output logic                 O_busy,
   output logic                 O_done,
   output logic                 O_err
);

   wb_state_e state;

   logic [DATA_W-1:0]    capResult;
   logic                 capBranch;
   logic                 capLoad;
   logic                 capStore;
   logic                 capRegwe;
   logic [REG_SEL_W-1:0] capRd;
   logic [DATA_W-1:0]    loadData;
   logic                 timedOut;
   logic                 errQ;
   logic                 timeoutHit;

   logic inLoad;
   logic inStore;

   // Decode the incoming memop; reserved 11 decodes as neither load nor store.
   assign inLoad  = (I_memop == MEMOP_LOAD);
   assign inStore = (I_memop == MEMOP_STORE);

`ifdef MEM_TIMEOUT_EN
   mem_req_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (I_clk),
      .rst_n   (I_rst_n),
      .run     (state == MEM),
      .expired (timeoutHit)
   );
`else
   assign timeoutHit = 1'b0;
`endif

   // Single FSM with registered outputs; strobes default low each cycle.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state       <= IDLE;
         capResult   <= '0;
         capBranch   <= 1'b0;
         capLoad     <= 1'b0;
         capStore    <= 1'b0;
         capRegwe    <= 1'b0;
         capRd       <= '0;
         loadData    <= '0;
         timedOut    <= 1'b0;
         errQ        <= 1'b0;
         O_mem_req   <= 1'b0;
         O_mem_we    <= 1'b0;
         O_mem_addr  <= '0;
         O_mem_wdata <= '0;
         O_reg_we    <= 1'b0;
         O_reg_sel   <= '0;
         O_reg_data  <= '0;
         O_pc_load   <= 1'b0;
         O_pc_target <= '0;
         O_done      <= 1'b0;
      end else begin
         O_reg_we  <= 1'b0;
         O_pc_load <= 1'b0;
         O_done    <= 1'b0;
         case (state)
            IDLE: begin
               if (I_en) begin
                  capResult <= I_aluresult;
                  capBranch <= I_shldBranch;
                  capLoad   <= inLoad && !I_shldBranch;
                  capStore  <= inStore && !I_shldBranch;
                  capRegwe  <= I_regwe;
                  capRd     <= I_rD_sel;
                  timedOut  <= 1'b0;
                  if (!I_shldBranch && (inLoad || inStore)) begin
                     O_mem_req   <= 1'b1;
                     O_mem_we    <= inStore;
                     O_mem_addr  <= I_aluresult;
                     O_mem_wdata <= I_storedata;
                     state       <= MEM;
                  end else begin
                     state <= COMMIT;
                  end
               end
            end
            MEM: begin
               if (I_mem_ack) begin
                  O_mem_req <= 1'b0;
                  loadData  <= I_mem_rdata;
                  state     <= COMMIT;
               end else if (timeoutHit) begin
                  O_mem_req <= 1'b0;
                  errQ      <= 1'b1;
                  timedOut  <= 1'b1;
                  state     <= COMMIT;
               end
            end
            COMMIT: begin
               O_done <= 1'b1;
               if (!timedOut) begin
                  if (capBranch) begin
                     O_pc_load   <= 1'b1;
                     O_pc_target <= capResult;
                  end else if (capRegwe && !capStore) begin
                     O_reg_we   <= 1'b1;
                     O_reg_sel  <= capRd;
                     O_reg_data <= capLoad ? loadData : capResult;
                  end
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Busy whenever the FSM is occupied; error flag is the sticky timeout register.
   assign O_busy = (state != IDLE);
   assign O_err  = errQ;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit; the timeout case runs only with MEM_TIMEOUT_EN.
module tb_writeback_unit;

   logic        clock;
   logic        rstN;
   logic        en;
   logic [15:0] aluResult;
   logic        shldBranch;
   logic [15:0] storeData;
   logic [1:0]  memop;
   logic        regwe;
   logic [2:0]  rdSel;
   logic        memReq;
   logic        memWe;
   logic [15:0] memAddr;
   logic [15:0] memWdata;
   logic        memAck;
   logic [15:0] memRdata;
   logic        regWe;
   logic [2:0]  regSel;
   logic [15:0] regData;
   logic        pcLoad;
   logic [15:0] pcTarget;
   logic        busy;
   logic        done;
   logic        err;

   int compared;
   int mismatched;

   writeback_unit #(
      .TIMEOUT (4)
   ) dut (
      .I_clk        (clock),
      .I_rst_n      (rstN),
      .I_en         (en),
      .I_aluresult  (aluResult),
      .I_shldBranch (shldBranch),
      .I_storedata  (storeData),
      .I_memop      (memop),
      .I_regwe      (regwe),
      .I_rD_sel     (rdSel),
      .O_mem_req    (memReq),
      .O_mem_we     (memWe),
      .O_mem_addr   (memAddr),
      .O_mem_wdata  (memWdata),
      .I_mem_ack    (memAck),
      .I_mem_rdata  (memRdata),
      .O_reg_we     (regWe),
      .O_reg_sel    (regSel),
      .O_reg_data   (regData),
      .O_pc_load    (pcLoad),
      .O_pc_target  (pcTarget),
      .O_busy       (busy),
      .O_done       (done),
      .O_err        (err)
   );

   // Free-running 10-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one value against its expectation and count mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance one posedge and come back to the following negedge for sampling/driving.
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Present one commit request for a single cycle, then return inputs to idle values.
   task automatic applyStimulus(input logic branch, input logic [15:0] result,
                                input logic [15:0] sdata, input logic [1:0] op,
                                input logic we, input logic [2:0] rd);
      en         = 1'b1;
      shldBranch = branch;
      aluResult  = result;
      storeData  = sdata;
      memop      = op;
      regwe      = we;
      rdSel      = rd;
      step();
      en         = 1'b0;
      shldBranch = 1'b0;
      aluResult  = 16'h0000;
      storeData  = 16'h0000;
      memop      = 2'b00;
      regwe      = 1'b0;
      rdSel      = 3'd0;
   endtask

   // Directed test sequence following the specification's testing list.
   initial begin
      compared   = 0;
      mismatched = 0;
      rstN       = 1'b0;
      en         = 1'b0;
      aluResult  = 16'h0000;
      shldBranch = 1'b0;
      storeData  = 16'h0000;
      memop      = 2'b00;
      regwe      = 1'b0;
      rdSel      = 3'd0;
      memAck     = 1'b0;
      memRdata   = 16'h0000;

      step();
      step();
      checkOutput("rst_req",   {15'd0, memReq}, 16'h0000);
      checkOutput("rst_busy",  {15'd0, busy},   16'h0000);
      checkOutput("rst_done",  {15'd0, done},   16'h0000);
      checkOutput("rst_regwe", {15'd0, regWe},  16'h0000);
      checkOutput("rst_pc",    {15'd0, pcLoad}, 16'h0000);
      checkOutput("rst_err",   {15'd0, err},    16'h0000);
      rstN = 1'b1;
      step();

      memAck = 1'b1;
      step();
      memAck = 1'b0;
      checkOutput("idle_ack_busy", {15'd0, busy}, 16'h0000);

      applyStimulus(1'b0, 16'h0042, 16'h0000, 2'b00, 1'b1, 3'd3);
      checkOutput("t1_busy", {15'd0, busy}, 16'h0001);
      checkOutput("t1_done_early", {15'd0, done}, 16'h0000);
      step();
      checkOutput("t1_regwe", {15'd0, regWe}, 16'h0001);
      checkOutput("t1_sel",   {13'd0, regSel}, 16'h0003);
      checkOutput("t1_data",  regData, 16'h0042);
      checkOutput("t1_done",  {15'd0, done}, 16'h0001);
      checkOutput("t1_pc",    {15'd0, pcLoad}, 16'h0000);
      step();
      checkOutput("t1_regwe_off", {15'd0, regWe}, 16'h0000);
      checkOutput("t1_done_off",  {15'd0, done}, 16'h0000);

      applyStimulus(1'b0, 16'h0100, 16'h0000, 2'b01, 1'b1, 3'd5);
      checkOutput("t2_req_c1",  {15'd0, memReq}, 16'h0001);
      checkOutput("t2_we",      {15'd0, memWe},  16'h0000);
      checkOutput("t2_addr",    memAddr, 16'h0100);
      checkOutput("t2_busy_c1", {15'd0, busy},   16'h0001);
      step();
      checkOutput("t2_req_c2",  {15'd0, memReq}, 16'h0001);
      step();
      checkOutput("t2_req_c3",  {15'd0, memReq}, 16'h0001);
      checkOutput("t2_busy_c3", {15'd0, busy},   16'h0001);
      memAck   = 1'b1;
      memRdata = 16'hBEEF;
      step();
      memAck   = 1'b0;
      memRdata = 16'h0000;
      checkOutput("t2_req_drop",   {15'd0, memReq}, 16'h0000);
      checkOutput("t2_busy_cm",    {15'd0, busy},   16'h0001);
      checkOutput("t2_done_early", {15'd0, done},   16'h0000);
      step();
      checkOutput("t2_done",  {15'd0, done},  16'h0001);
      checkOutput("t2_regwe", {15'd0, regWe}, 16'h0001);
      checkOutput("t2_sel",   {13'd0, regSel}, 16'h0005);
      checkOutput("t2_data",  regData, 16'hBEEF);

      applyStimulus(1'b0, 16'h0200, 16'h1234, 2'b10, 1'b1, 3'd6);
      checkOutput("t3_req",   {15'd0, memReq}, 16'h0001);
      checkOutput("t3_we",    {15'd0, memWe},  16'h0001);
      checkOutput("t3_addr",  memAddr,  16'h0200);
      checkOutput("t3_wdata", memWdata, 16'h1234);
      memAck = 1'b1;
      step();
      memAck = 1'b0;
      checkOutput("t3_req_drop", {15'd0, memReq}, 16'h0000);
      step();
      checkOutput("t3_done",  {15'd0, done},  16'h0001);
      checkOutput("t3_regwe", {15'd0, regWe}, 16'h0000);

      applyStimulus(1'b1, 16'h0080, 16'h0000, 2'b01, 1'b1, 3'd1);
      checkOutput("t4_req",  {15'd0, memReq}, 16'h0000);
      checkOutput("t4_busy", {15'd0, busy},   16'h0001);
      step();
      checkOutput("t4_pc",     {15'd0, pcLoad}, 16'h0001);
      checkOutput("t4_target", pcTarget, 16'h0080);
      checkOutput("t4_regwe",  {15'd0, regWe},  16'h0000);
      checkOutput("t4_done",   {15'd0, done},   16'h0001);
      step();
      checkOutput("t4_pc_off", {15'd0, pcLoad}, 16'h0000);

      applyStimulus(1'b0, 16'h7777, 16'h0000, 2'b11, 1'b1, 3'd2);
      checkOutput("rsv_req", {15'd0, memReq}, 16'h0000);
      step();
      checkOutput("rsv_regwe", {15'd0, regWe}, 16'h0001);
      checkOutput("rsv_data",  regData, 16'h7777);
      checkOutput("rsv_sel",   {13'd0, regSel}, 16'h0002);

      applyStimulus(1'b0, 16'h0300, 16'h0000, 2'b01, 1'b1, 3'd4);
      applyStimulus(1'b1, 16'h0999, 16'h0000, 2'b00, 1'b1, 3'd7);
      checkOutput("t5_req_kept",  {15'd0, memReq}, 16'h0001);
      checkOutput("t5_addr_kept", memAddr, 16'h0300);
      memAck   = 1'b1;
      memRdata = 16'h5555;
      step();
      memAck   = 1'b0;
      step();
      checkOutput("t5_done", {15'd0, done},   16'h0001);
      checkOutput("t5_data", regData, 16'h5555);
      checkOutput("t5_sel",  {13'd0, regSel}, 16'h0004);
      checkOutput("t5_pc",   {15'd0, pcLoad}, 16'h0000);
      step();
      checkOutput("t5_no_second_busy", {15'd0, busy}, 16'h0000);
      checkOutput("t5_no_second_done", {15'd0, done}, 16'h0000);

      applyStimulus(1'b0, 16'h0400, 16'h0000, 2'b01, 1'b1, 3'd1);
      checkOutput("t5r_req_pre", {15'd0, memReq}, 16'h0001);
      rstN = 1'b0;
      #1;
      checkOutput("t5r_req_rst",  {15'd0, memReq}, 16'h0000);
      checkOutput("t5r_busy_rst", {15'd0, busy},   16'h0000);
      @(negedge clock);
      rstN   = 1'b1;
      memAck = 1'b1;
      step();
      memAck = 1'b0;
      checkOutput("t5r_done_a", {15'd0, done}, 16'h0000);
      checkOutput("t5r_busy_a", {15'd0, busy}, 16'h0000);
      step();
      checkOutput("t5r_done_b",  {15'd0, done},  16'h0000);
      checkOutput("t5r_regwe_b", {15'd0, regWe}, 16'h0000);

`ifdef MEM_TIMEOUT_EN
      applyStimulus(1'b0, 16'h0500, 16'h0000, 2'b01, 1'b1, 3'd3);
      checkOutput("t6_req_c1", {15'd0, memReq}, 16'h0001);
      step();
      step();
      step();
      checkOutput("t6_req_c4",  {15'd0, memReq}, 16'h0001);
      checkOutput("t6_err_pre", {15'd0, err},    16'h0000);
      step();
      checkOutput("t6_req_drop", {15'd0, memReq}, 16'h0000);
      checkOutput("t6_err",      {15'd0, err},    16'h0001);
      step();
      checkOutput("t6_done",  {15'd0, done},   16'h0001);
      checkOutput("t6_regwe", {15'd0, regWe},  16'h0000);
      checkOutput("t6_pc",    {15'd0, pcLoad}, 16'h0000);
      step();
      step();
      checkOutput("t6_err_sticky", {15'd0, err}, 16'h0001);
`else
      checkOutput("err_tied", {15'd0, err}, 16'h0000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
